// File: rtl/face_classifier_mac_pipe.sv
// Pipelined signed multiply-accumulate for classifier dot products.
// Full-width products are summed per first/last-delimited vector, then rounded, shifted and saturated.
module face_classifier_mac_pipe #(
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 13,
  parameter int dout_WIDTH = 13,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 8,
  parameter int MUL_STAGES = 2,
  parameter bit SAT_EN     = 1'b1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_vld,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  ovf
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int RW = ACC_WIDTH + 1;

  logic [PW-1:0]         p_q [MUL_STAGES];
  logic [MUL_STAGES-1:0] vld_q, first_q, last_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < MUL_STAGES; i++) p_q[i] <= '0;
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (ce) begin
      p_q[0]     <= $signed(din0) * $signed(din1);
      vld_q[0]   <= in_vld;
      first_q[0] <= in_first;
      last_q[0]  <= in_last;
      for (int i = 1; i < MUL_STAGES; i++) begin
        p_q[i]     <= p_q[i-1];
        vld_q[i]   <= vld_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  logic                 p_vld, p_first, p_last;
  logic [ACC_WIDTH-1:0] p_ext, acc_q, acc_sum, acc_new;
  logic                 sticky_q, sticky_new, add_ovf, res_q;

  assign p_vld   = vld_q[MUL_STAGES-1];
  assign p_first = first_q[MUL_STAGES-1];
  assign p_last  = last_q[MUL_STAGES-1];
  assign p_ext   = ACC_WIDTH'($signed(p_q[MUL_STAGES-1]));
  assign acc_sum = acc_q + p_ext;
  // Signed overflow: both addends share a sign the wrapped sum does not.
  assign add_ovf = (acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                   (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  assign acc_new    = p_first ? p_ext : acc_sum;
  assign sticky_new = p_first ? 1'b0 : (sticky_q | add_ovf);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      res_q    <= 1'b0;
    end else if (ce) begin
      res_q <= p_vld & p_last;
      if (p_vld) begin
        acc_q    <= acc_new;
        sticky_q <= sticky_new;
      end
    end
  end

  // Output stage reads the registered sum, so a following first can overwrite acc_q freely.
  logic [RW-1:0]         acc_x;
  logic signed [RW-1:0]  r;
  logic                  oor;
  logic [dout_WIDTH-1:0] dout_nxt;

  assign acc_x = {acc_q[ACC_WIDTH-1], acc_q};

  generate
    if (FRAC_BITS > 0) begin : g_round
      localparam logic [RW-1:0] HALF = RW'(1) << (FRAC_BITS - 1);
      logic [RW-1:0] rnd;
      assign rnd = acc_x + HALF;
      assign r   = $signed(rnd) >>> FRAC_BITS;
    end else begin : g_noround
      assign r = $signed(acc_x);
    end
  endgenerate

  // In range exactly when every bit above the dout sign bit matches it.
  assign oor = ~((&r[RW-1:dout_WIDTH-1]) | ~(|r[RW-1:dout_WIDTH-1]));

  always_comb begin
    dout_nxt = r[dout_WIDTH-1:0];
    if (SAT_EN && oor) dout_nxt = {r[RW-1], {(dout_WIDTH-1){~r[RW-1]}}};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else if (ce) begin
      dout_vld <= res_q;
      if (res_q) begin
        dout <= dout_nxt;
        ovf  <= sticky_q | oor;
      end
    end
  end

endmodule
